// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter_ctrl command initiator: command opcodes, FSM
// states and the boundary-step helper used by the controller.
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_UP   = 2'd1,
      OP_DOWN = 2'd2,
      OP_HOLD = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_WAIT,
      ST_DONE
   } ctrl_state_e;

   // True when a step issued now in direction `up` would cross the counter boundary.
   function automatic logic is_boundary(input logic up, input logic max_count, input logic zero);
      return up ? max_count : zero;
   endfunction

endpackage

// File: rtl/counter_ctrl_step_timer.sv
// Loadable STEP_W down-counter shared by the RUN and WAIT phases of counter_ctrl;
// `last` flags the final active cycle (value == 1).
module ctrl_step_timer #(
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              dec,
   input  logic [STEP_W-1:0] load_value,
   output logic              last
);

   logic [STEP_W-1:0] value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (dec && (value != '0)) begin
         value <= value - STEP_W'(1);
      end
   end

   assign last = (value == STEP_W'(1));

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven initiator for an up/down loadable counter. Optional macro
// CTRL_SATURATE_EN stops at the counter boundary instead of wrapping.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [WIDTH-1:0]  cmd_data,
   input  logic [STEP_W-1:0] cmd_steps,
   output logic              load_n,
   output logic              up_down,
   output logic              ce,
   output logic [WIDTH-1:0]  data_load,
   input  logic              max_count,
   input  logic              zero,
   output logic              done,
   output logic              wrapped
);

   ctrl_state_e state;
   logic        ce_q;
   logic        accept;
   logic        boundary;
   logic        wrap_step;
   logic        timer_last;

`ifdef CTRL_SATURATE_EN
   localparam bit SATURATE = 1'b1;
   // NOTE: the boundary flags describe the current count, so the blocked step must be
   // suppressed in the same cycle; a registered gate would let one wrapping step through.
   assign ce = ce_q & ~boundary;
`else
   localparam bit SATURATE = 1'b0;
   assign ce = ce_q;
`endif

   assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
   assign boundary  = is_boundary(up_down, max_count, zero);
   assign wrap_step = ce_q && boundary;

   ctrl_step_timer #(.STEP_W(STEP_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (accept),
      .dec        ((state == ST_RUN) || (state == ST_WAIT)),
      .load_value (cmd_steps),
      .last       (timer_last)
   );

   // NOTE: every register here uses non-blocking assignment so all outputs change
   // together on the edge and never observe each other's next value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b1;
         load_n    <= 1'b1;
         up_down   <= 1'b1;
         ce_q      <= 1'b0;
         data_load <= '0;
         done      <= 1'b0;
         wrapped   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cmd_ready <= 1'b0;
                  wrapped   <= 1'b0;
                  case (cmd_op_e'(cmd_op))
                     OP_LOAD: begin
                        state     <= ST_LOAD;
                        load_n    <= 1'b0;
                        data_load <= cmd_data;
                     end
                     OP_UP, OP_DOWN: begin
                        if (cmd_steps == '0) begin
                           state <= ST_DONE;
                           done  <= 1'b1;
                        end else begin
                           state   <= ST_RUN;
                           ce_q    <= 1'b1;
                           up_down <= (cmd_op_e'(cmd_op) == OP_UP);
                        end
                     end
                     default: begin
                        if (cmd_steps == '0) begin
                           state <= ST_DONE;
                           done  <= 1'b1;
                        end else begin
                           state <= ST_WAIT;
                        end
                     end
                  endcase
               end
            end
            ST_LOAD: begin
               load_n <= 1'b1;
               state  <= ST_DONE;
               done   <= 1'b1;
            end
            ST_RUN: begin
               if (wrap_step) wrapped <= 1'b1;
               // A blocked boundary step ends the command; the rest of its steps are dropped.
               if (timer_last || (SATURATE && wrap_step)) begin
                  ce_q  <= 1'b0;
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (timer_last) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
               ce_q      <= 1'b0;
               load_n    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl driving a behavioural 4-bit up/down counter;
// honours CTRL_SATURATE_EN for the boundary expectations.
module tb_counter_ctrl;
   import counter_ctrl_pkg::*;

   localparam int WIDTH  = 4;
   localparam int STEP_W = 8;

`ifdef CTRL_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [WIDTH-1:0]  cmd_data;
   logic [STEP_W-1:0] cmd_steps;
   logic              load_n;
   logic              up_down;
   logic              ce;
   logic [WIDTH-1:0]  data_load;
   logic              max_count;
   logic              zero;
   logic              done;
   logic              wrapped;
   logic [WIDTH-1:0]  count_out;

   always #5 clk = ~clk;

   counter_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_steps (cmd_steps),
      .load_n    (load_n),
      .up_down   (up_down),
      .ce        (ce),
      .data_load (data_load),
      .max_count (max_count),
      .zero      (zero),
      .done      (done),
      .wrapped   (wrapped)
   );

   // Downstream counter being driven.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       count_out <= '0;
      else if (!load_n) count_out <= data_load;
      else if (ce)      count_out <= up_down ? count_out + 4'd1 : count_out - 4'd1;
   end
   assign max_count = (count_out == 4'hF);
   assign zero      = (count_out == 4'h0);

   typedef struct {
      string      tag;
      int         lat;
      int         ce_n;
      int         ld_n;
      logic [3:0] count;
      logic       wrapped;
      logic       ud;
      logic [3:0] dl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(string tag, int lat, int ce_n, int ld_n, logic [3:0] count,
                               logic wr, logic ud, logic [3:0] dl);
      exp_t e;
      e.tag = tag; e.lat = lat; e.ce_n = ce_n; e.ld_n = ld_n;
      e.count = count; e.wrapped = wr; e.ud = ud; e.dl = dl;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Drive a command, wait (bounded) for acceptance, queue its expectation.
   task automatic issue(input cmd_op_e op, input logic [3:0] d, input logic [7:0] s,
                        input bit keep, input exp_t e);
      int w = 0;
      @(negedge clk);
      cmd_op = op; cmd_data = d; cmd_steps = s; cmd_valid = 1'b1;
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({e.tag, "_accept"}, 32'(w < 100), 32'd1);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   // Observe the active command until done, then compare against the oldest expectation.
   task automatic collect();
      exp_t       e;
      int         cyc = 0, ce_n = 0, ld_n = 0;
      bit         seen = 0, overlap = 0, ud_bad = 0, busy_ready = 0;
      logic [3:0] dl = '0;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (ce) begin
            ce_n++;
            if (up_down !== e.ud) ud_bad = 1;
         end
         if (!load_n) begin
            ld_n++;
            dl = data_load;
         end
         if (done) begin
            seen = 1;
            if (cmd_ready) overlap = 1;
         end else if (cmd_ready) begin
            busy_ready = 1;
         end
      end
      check({e.tag, "_done_seen"},  32'(seen),      32'd1);
      check({e.tag, "_latency"},    32'(cyc),       32'(e.lat));
      check({e.tag, "_ce_cycles"},  32'(ce_n),      32'(e.ce_n));
      check({e.tag, "_load_cycles"},32'(ld_n),      32'(e.ld_n));
      check({e.tag, "_count_out"},  32'(count_out), 32'(e.count));
      check({e.tag, "_wrapped"},    32'(wrapped),   32'(e.wrapped));
      check({e.tag, "_ready_done"}, 32'(overlap),   32'd0);
      check({e.tag, "_ready_busy"}, 32'(busy_ready),32'd0);
      check({e.tag, "_up_down"},    32'(ud_bad),    32'd0);
      if (e.ld_n > 0) check({e.tag, "_data_load"}, 32'(dl), 32'(e.dl));
      @(negedge clk);
      check({e.tag, "_done_pulse"}, 32'(done),      32'd0);
      check({e.tag, "_ready_after"},32'(cmd_ready), 32'd1);
   endtask

   initial begin
      exp_t scrap;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; cmd_steps = '0;
      #12;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_load_n",    32'(load_n),    32'd1);
      check("rst_up_down",   32'(up_down),   32'd1);
      check("rst_ce",        32'(ce),        32'd0);
      check("rst_data_load", 32'(data_load), 32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_wrapped",   32'(wrapped),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(OP_LOAD, 4'd9, 8'd0, 1'b0, mk("load9", 2, 0, 1, 4'd9, 1'b0, 1'b1, 4'd9));
      collect();
      issue(OP_UP, 4'd0, 8'd3, 1'b0, mk("up3", 4, 3, 0, 4'd12, 1'b0, 1'b1, 4'd0));
      collect();

      issue(OP_LOAD, 4'd13, 8'd0, 1'b0, mk("load13", 2, 0, 1, 4'd13, 1'b0, 1'b1, 4'd13));
      collect();
      if (SAT) issue(OP_UP, 4'd0, 8'd4, 1'b0, mk("up4_wrap", 4, 2, 0, 4'd15, 1'b1, 1'b1, 4'd0));
      else     issue(OP_UP, 4'd0, 8'd4, 1'b0, mk("up4_wrap", 5, 4, 0, 4'd1,  1'b1, 1'b1, 4'd0));
      collect();

      issue(OP_LOAD, 4'd1, 8'd0, 1'b0, mk("load1", 2, 0, 1, 4'd1, 1'b0, 1'b1, 4'd1));
      collect();
      if (SAT) issue(OP_DOWN, 4'd0, 8'd2, 1'b0, mk("down2_wrap", 3, 1, 0, 4'd0,  1'b1, 1'b0, 4'd0));
      else     issue(OP_DOWN, 4'd0, 8'd2, 1'b0, mk("down2_wrap", 3, 2, 0, 4'd15, 1'b1, 1'b0, 4'd0));
      collect();

      issue(OP_UP, 4'd0, 8'd0, 1'b0,
            mk("up0", 1, 0, 0, SAT ? 4'd0 : 4'd15, 1'b0, 1'b1, 4'd0));
      collect();

      // HOLD with cmd_valid left high; the fields change to a LOAD that must wait for done.
      issue(OP_HOLD, 4'd0, 8'd5, 1'b1,
            mk("hold5", 6, 0, 0, SAT ? 4'd0 : 4'd15, 1'b0, 1'b1, 4'd0));
      cmd_op = OP_LOAD; cmd_data = 4'd3; cmd_steps = 8'd7;
      sb.push_back(mk("pending_load3", 2, 0, 1, 4'd3, 1'b0, 1'b1, 4'd3));
      collect();
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      collect();

      // Asynchronous reset in the middle of a RUN.
      issue(OP_UP, 4'd0, 8'd10, 1'b0, mk("up10_reset", 0, 0, 0, 4'd0, 1'b0, 1'b1, 4'd0));
      scrap = sb.pop_front();
      repeat (2) @(negedge clk);
      check("mid_run_ce", 32'(ce), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ce",        32'(ce),        32'd0);
      check("async_rst_load_n",    32'(load_n),    32'd1);
      check("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("async_rst_up_down",   32'(up_down),   32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      issue(OP_LOAD, 4'd5, 8'd0, 1'b0, mk("load5_after_rst", 2, 0, 1, 4'd5, 1'b0, 1'b1, 4'd5));
      collect();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
